video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_pkg.sv | 41 ++++
 rtl/video_pattern_gen.sv | 45 ++++
 rtl/video_timing_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared timing defaults, FSM and pattern enums,
// colour-bar table and output bundle for video_timing_gen.
package video_pkg;

  // 1080p60 timing
  localparam int H_ACTIVE_D = 1920;
  localparam int H_FP_D     = 88;
  localparam int H_SYNC_D   = 44;
  localparam int H_BP_D     = 148;
  localparam int V_ACTIVE_D = 1080;
  localparam int V_FP_D     = 4;
  localparam int V_SYNC_D   = 5;
  localparam int V_BP_D     = 36;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_RAMP,
    PAT_CHECK,
    PAT_FLAT
  } pat_e;

  // Bar colours, left to right
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic [23:0] rgb;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic        fs;
  } vid_out_t;

endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: combinational test pattern for pixel (x, y).
// Ports: x, y counters, frame_cnt, pat_sel in; rgb out.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D
) (
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [7:0]  frame_cnt,
  input  pat_e        pat_sel,
  output logic [23:0] rgb
);

  localparam int BW = H_ACTIVE / 8;

  logic [2:0] idx;
  logic       chk;
  logic       unused;

  // Bar index: count thresholds passed, no divider
  always_comb begin
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= 12'(k * BW)) idx = 3'(k);
    end
  end

  assign chk = x[6] ^ y[6] ^ frame_cnt[5];

  assign unused = ^{y[11:7], y[5:0],
                    frame_cnt[7:6], frame_cnt[4:0]};

  always_comb begin
    rgb = '0;
    unique case (pat_sel)
      PAT_BARS:  rgb = BAR_RGB[idx];
      PAT_RAMP:  rgb = {3{x[10:3]}};
      PAT_CHECK: rgb = {24{chk}};
      PAT_FLAT:  rgb = 24'h808080;
      default:   rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, run/drain FSM and registered
// video outputs (rgb, blanks, syncs, frame start, frame count).
// Ports: clk_i, rst_ni, cen_i, en_i, pat_sel_i in;
// vid_rgb_o, vh_blank_o, dvh_sync_o, frame_start_o, frame_cnt_o out.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic        en_i,
  input  logic [1:0]  pat_sel_i,
  output logic [23:0] vid_rgb_o,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic        frame_start_o,
  output logic [7:0]  frame_cnt_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOT - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOT - 1);
  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);

  state_e      state_q;
  logic [11:0] h_q;
  logic [11:0] v_q;
  logic [7:0]  fc_q;
  pat_e        pat_q;
  vid_out_t    out_q;
  vid_out_t    pix;

  logic        go;
  logic        at_org;
  logic        h_end;
  logic        wrap;
  logic        hb;
  logic        vb;
  logic        de;
  pat_e        pat_cur;
  logic [23:0] rgb;

  assign go     = (state_q != ST_OFF) || en_i;
  assign at_org = (h_q == '0) && (v_q == '0);
  assign h_end  = h_q == H_LAST;
  assign wrap   = h_end && (v_q == V_LAST);
  assign hb     = h_q >= HA;
  assign vb     = v_q >= VA;
  assign de     = !hb && !vb;

  // New select takes effect on the frame's first pixel
  assign pat_cur = at_org ? pat_e'(pat_sel_i) : pat_q;

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pat (
    .x         (h_q),
    .y         (v_q),
    .frame_cnt (fc_q),
    .pat_sel   (pat_cur),
    .rgb       (rgb)
  );

  always_comb begin
    pix          = '0;
    pix.rgb      = de ? rgb : '0;
    pix.vh_blank = {vb, hb};
    pix.dvh_sync = {de,
                    (v_q >= VS0) && (v_q < VS1),
                    (h_q >= HS0) && (h_q < HS1)};
    pix.fs       = at_org;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      h_q     <= '0;
      v_q     <= '0;
      fc_q    <= '0;
      pat_q   <= PAT_BARS;
      out_q   <= '0;
    end else if (cen_i) begin
      if (!go) begin
        out_q <= '0;
      end else begin
        out_q <= pix;
        if (at_org) pat_q <= pat_cur;
        h_q <= h_end ? '0 : h_q + 12'd1;
        if (h_end) v_q <= wrap ? '0 : v_q + 12'd1;
        // Frame end with en low leaves for OFF
        if (wrap) fc_q <= en_i ? fc_q + 8'd1 : '0;
        unique case (state_q)
          ST_OFF: state_q <= ST_RUN;
          ST_RUN: begin
            if (!en_i) state_q <= wrap ? ST_OFF : ST_DRAIN;
          end
          ST_DRAIN: begin
            if (en_i) state_q <= ST_RUN;
            else if (wrap) state_q <= ST_OFF;
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign vid_rgb_o     = out_q.rgb;
  assign vh_blank_o    = out_q.vh_blank;
  assign dvh_sync_o    = out_q.dvh_sync;
  assign frame_start_o = out_q.fs;
  assign frame_cnt_o   = fc_q;

endmodule
